// File: rtl/config_loader_pkg.sv
// Shared definitions for the serial configuration chain loader.
//   cfg_state_e       : loader FSM states (IDLE, LOAD, SHIFT, DONE)
//   CFG_CHAIN_LEN_DEF : default number of config bits in the downstream chain
//   CFG_WORD_W_DEF    : default width of incoming configuration words
//   cfg_words()       : number of words needed to cover a chain (ceiling division)
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } cfg_state_e;

  localparam int unsigned CFG_CHAIN_LEN_DEF = 64;
  localparam int unsigned CFG_WORD_W_DEF    = 32;

  function automatic int unsigned cfg_words(input int unsigned chain_len,
                                            input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/config_chain_loader_serializer.sv
// cfg_word_serializer: holds one configuration word and walks a bit index
// across it, LSB first.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture word_in and restart the index at bit 0
//   advance    : step to the next bit (ignored when load is high)
//   word_in    : word to capture
//   cur_bit    : bit currently selected by the index
//   word_end   : index is on the final bit of the word
//   pre_end    : index is on the second-to-last bit of the word
module cfg_word_serializer
  import config_loader_pkg::*;
#(
  parameter int unsigned WORD_W = CFG_WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [WORD_W-1:0] word_in,
  output logic              cur_bit,
  output logic              word_end,
  output logic              pre_end
);

  localparam int unsigned     IW      = $clog2(WORD_W);
  localparam logic [IW-1:0]   IDX_END = IW'(WORD_W - 1);
  localparam logic [IW-1:0]   IDX_PRE = IW'(WORD_W - 2);

  logic [WORD_W-1:0] sreg;
  logic [IW-1:0]     bit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_idx <= '0;
    end else if (load) begin
      sreg    <= word_in;
      bit_idx <= '0;
    end else if (advance) begin
      bit_idx <= bit_idx + IW'(1);
    end
  end

  assign cur_bit  = sreg[bit_idx];
  assign word_end = (bit_idx == IDX_END);
  assign pre_end  = (bit_idx == IDX_PRE);

endmodule

// File: rtl/config_chain_loader.sv
// config_chain_loader: transmit end of the serial configuration chain.
// Accepts words over valid/ready, shifts exactly CHAIN_LEN bits LSB-first into
// the chain head, stalls with cfg_en low while words are late, pulses done.
// Optional build macro: CONFIG_READBACK_SIG_EN (rotate-XOR signature of the
// bits returned on cfg_tail; when undefined sig_out is tied to zero).
// Ports:
//   config_clk, config_reset : clock, asynchronous active-low reset
//   start, abort             : begin a load (IDLE only) / cancel a load
//   word_data/valid/ready    : configuration word stream
//   cfg_bit, cfg_en          : serial data and shift enable to the chain head
//   cfg_tail                 : chain tail loop-back
//   busy, done               : load in progress / one-cycle completion pulse
//   sig_out                  : readback signature
module config_chain_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CFG_CHAIN_LEN_DEF,
  parameter int unsigned WORD_W    = CFG_WORD_W_DEF,
  parameter int unsigned SIG_W     = 16
) (
  input  logic              config_clk,
  input  logic              config_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_bit,
  output logic              cfg_en,
  input  logic              cfg_tail,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  sig_out
);

  localparam int unsigned   RW  = $clog2(CHAIN_LEN + 1);
  localparam logic [RW-1:0] LEN = RW'(CHAIN_LEN);

  cfg_state_e    state;
  logic [RW-1:0] remaining;
  logic          word_ready_q, cfg_en_q, busy_q, done_q;
  logic          accept, advance, last_bit;
  logic          cur_bit, word_end, pre_end;

  // abort wins over a same-cycle handshake, so it masks ready combinationally
  assign word_ready = word_ready_q & ~abort;
  assign accept     = word_ready & word_valid;
  assign advance    = (state == SHIFT) & ~word_end;
  assign last_bit   = (remaining == RW'(1));

  assign cfg_en  = cfg_en_q;
  assign cfg_bit = cfg_en_q & cur_bit;
  assign busy    = busy_q;
  assign done    = done_q;

  cfg_word_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk      (config_clk),
    .rst_n    (config_reset),
    .load     (accept),
    .advance  (advance),
    .word_in  (word_data),
    .cur_bit  (cur_bit),
    .word_end (word_end),
    .pre_end  (pre_end)
  );

  // Outputs are registered, so word_ready_q is decided one cycle ahead:
  // it is set for the coming cycle when that cycle will sit on the last bit
  // of a word and that bit is not the final bit of the chain.
  always_ff @(posedge config_clk or negedge config_reset) begin
    if (!config_reset) begin
      state        <= IDLE;
      remaining    <= '0;
      word_ready_q <= 1'b0;
      cfg_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state != IDLE)) begin
        state        <= IDLE;
        word_ready_q <= 1'b0;
        cfg_en_q     <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state        <= LOAD;
              remaining    <= LEN;
              word_ready_q <= 1'b1;
              busy_q       <= 1'b1;
            end
          end
          LOAD: begin
            if (accept) begin
              state        <= SHIFT;
              word_ready_q <= 1'b0;
              cfg_en_q     <= 1'b1;
            end
          end
          SHIFT: begin
            remaining <= remaining - RW'(1);
            if (last_bit) begin
              state        <= DONE;
              word_ready_q <= 1'b0;
              cfg_en_q     <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end else if (word_end) begin
              if (accept) begin
                word_ready_q <= 1'b0;
              end else begin
                state        <= LOAD;
                word_ready_q <= 1'b1;
                cfg_en_q     <= 1'b0;
              end
            end else begin
              word_ready_q <= pre_end && (remaining != RW'(2));
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef CONFIG_READBACK_SIG_EN
  logic [SIG_W-1:0] sig;

  always_ff @(posedge config_clk or negedge config_reset) begin
    if (!config_reset) begin
      sig <= '0;
    end else if ((state == IDLE) && start) begin
      sig <= '0;
    end else if (cfg_en_q) begin
      sig <= {sig[SIG_W-2:0], sig[SIG_W-1] ^ cfg_tail};
    end
  end

  assign sig_out = sig;
`else
  logic unused_tail;
  assign unused_tail = cfg_tail;
  assign sig_out     = '0;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
module tb_config_chain_loader;

  localparam int unsigned CHAIN_LEN = 40;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned SIG_W     = 16;
  localparam int unsigned NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic              config_clk   = 1'b0;
  logic              config_reset = 1'b0;
  logic              start        = 1'b0;
  logic              abort        = 1'b0;
  logic              word_valid   = 1'b0;
  logic [WORD_W-1:0] word_data    = '0;
  logic              word_ready, cfg_bit, cfg_en, cfg_tail, busy, done;
  logic [SIG_W-1:0]  sig_out;

  logic [CHAIN_LEN-1:0] chain_m     = '0;
  logic                 preload_req = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        exp_q[$];

  always #5 config_clk = ~config_clk;

  // downstream chain: head takes cfg_bit, tail returns the oldest bit
  always @(posedge config_clk) begin
    if (preload_req) chain_m <= '1;
    else if (cfg_en) chain_m <= {chain_m[CHAIN_LEN-2:0], cfg_bit};
  end
  assign cfg_tail = chain_m[CHAIN_LEN-1];

  config_chain_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W),
    .SIG_W     (SIG_W)
  ) dut (
    .config_clk   (config_clk),
    .config_reset (config_reset),
    .start        (start),
    .abort        (abort),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .cfg_bit      (cfg_bit),
    .cfg_en       (cfg_en),
    .cfg_tail     (cfg_tail),
    .busy         (busy),
    .done         (done),
    .sig_out      (sig_out)
  );

  // One load: pushes expected bits on each handshake, pops one per cfg_en cycle.
  task automatic do_load(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                         input int unsigned stall, input int unsigned abort_at,
                         input bit poke_start,
                         output int unsigned n_en, output int unsigned n_hs,
                         output int unsigned n_done, output int unsigned n_low);
    logic [WORD_W-1:0] words [2];
    int unsigned stalled, cyc, nb;
    bit prev_en, finished, aborted;
    logic exp_b;
    words[0] = w0;
    words[1] = w1;
    n_en = 0; n_hs = 0; n_done = 0; n_low = 0;
    stalled = 0; cyc = 0; prev_en = 1'b0; finished = 1'b0; aborted = 1'b0;
    exp_q.delete();
    @(negedge config_clk);
    start = 1'b1;
    while (!finished && cyc < 300) begin
      @(negedge config_clk);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      if (cfg_en) begin
        n_en++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_bit: cfg_en high at bit %0d, required no further bits", n_en);
        end else begin
          exp_b = exp_q.pop_front();
          if (cfg_bit !== exp_b) begin
            n_err++;
            $display("FAIL cfg_bit[%0d]: got %b required %b", n_en - 1, cfg_bit, exp_b);
          end
        end
      end else begin
        n_cmp++;
        if (cfg_bit !== 1'b0) begin
          n_err++;
          $display("FAIL idle_bit: cfg_bit got %b required 0 while cfg_en low", cfg_bit);
        end
      end
      if (busy && !cfg_en && n_en > 0) n_low++;
      if (aborted) begin
        n_cmp++;
        if ({cfg_en, busy, done, word_ready} !== 4'b0000) begin
          n_err++;
          $display("FAIL abort_next: {cfg_en,busy,done,word_ready} got %b required 0000",
                   {cfg_en, busy, done, word_ready});
        end
        finished = 1'b1;
      end
      if (done) begin
        n_done++;
        n_cmp++;
        if (!(prev_en && n_en == CHAIN_LEN)) begin
          n_err++;
          $display("FAIL done_timing: prev_en=%b bits=%0d required prev_en=1 bits=%0d",
                   prev_en, n_en, CHAIN_LEN);
        end
        if (poke_start) start = 1'b1;
        finished = 1'b1;
      end
      prev_en = cfg_en;
      word_valid = 1'b0;
      if (!finished) begin
        if (abort_at != 0 && cfg_en && n_en == abort_at) begin
          abort   = 1'b1;
          aborted = 1'b1;
        end
        if (poke_start && cfg_en && n_en == 10) start = 1'b1;
        if (n_hs < NWORDS) begin
          if (n_hs == 1 && stalled < stall) begin
            if (word_ready) stalled++;
          end else begin
            word_valid = 1'b1;
            word_data  = words[n_hs];
          end
        end
      end
      #1;
      if (word_valid && word_ready) begin
        nb = (n_hs == NWORDS - 1) ? CHAIN_LEN - (NWORDS - 1) * WORD_W : WORD_W;
        for (int unsigned i = 0; i < nb; i++) exp_q.push_back(word_data[i]);
        n_hs++;
      end
    end
    word_valid = 1'b0;
    abort      = 1'b0;
    n_cmp++;
    if (!finished) begin
      n_err++;
      $display("FAIL load_timeout: no done/abort after %0d cycles, required completion", cyc);
    end
    if (!aborted) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL leftover_bits: got %0d unshifted required 0", exp_q.size());
      end
    end
    @(negedge config_clk);
    start = 1'b0;
    n_cmp++;
    if ({busy, word_ready, cfg_en, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL post_idle: {busy,word_ready,cfg_en,done} got %b required 0000",
               {busy, word_ready, cfg_en, done});
    end
  endtask

  task automatic test_reset();
    config_reset = 1'b0;
    #3;
    n_cmp++;
    if ({word_ready, cfg_bit, cfg_en, busy, done} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 00000",
               {word_ready, cfg_bit, cfg_en, busy, done});
    end
    n_cmp++;
    if (sig_out !== '0) begin
      n_err++;
      $display("FAIL reset_sig: got %h required 0", sig_out);
    end
    @(negedge config_clk);
    config_reset = 1'b1;
    repeat (2) @(negedge config_clk);
    n_cmp++;
    if ({word_ready, busy, cfg_en, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_idle: got %b required 0000", {word_ready, busy, cfg_en, done});
    end
  endtask

  task automatic check_counts(input string tag, input int unsigned n_en, input int unsigned n_hs,
                              input int unsigned n_done, input int unsigned n_low,
                              input int unsigned want_en, input int unsigned want_done,
                              input int unsigned want_low);
    n_cmp++;
    if (n_en != want_en) begin
      n_err++;
      $display("FAIL %s_enables: got %0d required %0d", tag, n_en, want_en);
    end
    n_cmp++;
    if (n_done != want_done) begin
      n_err++;
      $display("FAIL %s_done_pulses: got %0d required %0d", tag, n_done, want_done);
    end
    n_cmp++;
    if (n_low != want_low) begin
      n_err++;
      $display("FAIL %s_stall_cycles: got %0d required %0d", tag, n_low, want_low);
    end
    if (want_done != 0) begin
      n_cmp++;
      if (n_hs != NWORDS) begin
        n_err++;
        $display("FAIL %s_handshakes: got %0d required %0d", tag, n_hs, NWORDS);
      end
    end
  endtask

  task automatic test_basic_load();
    int unsigned n_en, n_hs, n_done, n_low;
    do_load(32'hA5A5_0F0F, 32'h0000_00C3, 0, 0, 1'b0, n_en, n_hs, n_done, n_low);
    check_counts("basic", n_en, n_hs, n_done, n_low, CHAIN_LEN, 1, 0);
  endtask

  task automatic test_stall();
    int unsigned n_en, n_hs, n_done, n_low;
    do_load(32'hA5A5_0F0F, 32'h0000_00C3, 5, 0, 1'b0, n_en, n_hs, n_done, n_low);
    check_counts("stall", n_en, n_hs, n_done, n_low, CHAIN_LEN, 1, 5);
  endtask

  task automatic test_abort();
    int unsigned n_en, n_hs, n_done, n_low;
    do_load(32'hA5A5_0F0F, 32'h0000_00C3, 0, 20, 1'b0, n_en, n_hs, n_done, n_low);
    check_counts("abort", n_en, n_hs, n_done, n_low, 20, 0, 0);
    do_load(32'h0F0F_A5A5, 32'h0000_003C, 0, 0, 1'b0, n_en, n_hs, n_done, n_low);
    check_counts("after_abort", n_en, n_hs, n_done, n_low, CHAIN_LEN, 1, 0);
  endtask

  task automatic test_start_ignored();
    int unsigned n_en, n_hs, n_done, n_low;
    do_load(32'h1357_9BDF, 32'h0000_0081, 0, 0, 1'b1, n_en, n_hs, n_done, n_low);
    check_counts("start_ignored", n_en, n_hs, n_done, n_low, CHAIN_LEN, 1, 0);
  endtask

  task automatic test_back_to_back();
    int unsigned n_en, n_hs, n_done, n_low;
    // upper bits of the final word must never reach the chain
    do_load(32'hDEAD_BEEF, 32'hFFFF_FF3C, 0, 0, 1'b0, n_en, n_hs, n_done, n_low);
    check_counts("b2b_a", n_en, n_hs, n_done, n_low, CHAIN_LEN, 1, 0);
    do_load(32'h8000_0001, 32'h5555_5555, 0, 0, 1'b0, n_en, n_hs, n_done, n_low);
    check_counts("b2b_b", n_en, n_hs, n_done, n_low, CHAIN_LEN, 1, 0);
  endtask

  task automatic test_async_reset();
    int unsigned cyc, seen;
    cyc = 0;
    seen = 0;
    @(negedge config_clk);
    start      = 1'b1;
    word_valid = 1'b1;
    word_data  = 32'h1234_5678;
    @(negedge config_clk);
    start = 1'b0;
    while (seen < 10 && cyc < 100) begin
      @(negedge config_clk);
      cyc++;
      if (cfg_en) seen++;
    end
    n_cmp++;
    if (seen != 10) begin
      n_err++;
      $display("FAIL async_reach_shift: got %0d enables required 10", seen);
    end
    #2;
    config_reset = 1'b0;
    #1;
    n_cmp++;
    if ({word_ready, cfg_bit, cfg_en, busy, done} !== 5'b00000) begin
      n_err++;
      $display("FAIL async_reset_outputs: got %b required 00000",
               {word_ready, cfg_bit, cfg_en, busy, done});
    end
    n_cmp++;
    if (sig_out !== '0) begin
      n_err++;
      $display("FAIL async_reset_sig: got %h required 0", sig_out);
    end
    repeat (2) @(negedge config_clk);
    word_valid   = 1'b0;
    config_reset = 1'b1;
    @(negedge config_clk);
    n_cmp++;
    if ({word_ready, busy, cfg_en, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL async_release_idle: got %b required 0000", {word_ready, busy, cfg_en, done});
    end
  endtask

  task automatic test_signature();
    int unsigned n_en, n_hs, n_done, n_low;
    logic [SIG_W-1:0] exp_sig;
    exp_sig = '0;
`ifdef CONFIG_READBACK_SIG_EN
    for (int unsigned i = 0; i < CHAIN_LEN; i++)
      exp_sig = {exp_sig[SIG_W-2:0], exp_sig[SIG_W-1] ^ 1'b1};
`endif
    @(negedge config_clk);
    preload_req = 1'b1;
    @(negedge config_clk);
    preload_req = 1'b0;
    do_load(32'hA5A5_0F0F, 32'h0000_00C3, 0, 0, 1'b0, n_en, n_hs, n_done, n_low);
    check_counts("sig_load", n_en, n_hs, n_done, n_low, CHAIN_LEN, 1, 0);
    n_cmp++;
    if (sig_out !== exp_sig) begin
      n_err++;
      $display("FAIL signature: got %h required %h", sig_out, exp_sig);
    end
    repeat (3) @(negedge config_clk);
    n_cmp++;
    if (sig_out !== exp_sig) begin
      n_err++;
      $display("FAIL signature_hold: got %h required %h", sig_out, exp_sig);
    end
    start = 1'b1;
    @(negedge config_clk);
    start = 1'b0;
    n_cmp++;
    if ({busy, sig_out} !== {1'b1, {SIG_W{1'b0}}}) begin
      n_err++;
      $display("FAIL signature_clear: busy=%b sig=%h required busy=1 sig=0", busy, sig_out);
    end
    abort = 1'b1;
    @(negedge config_clk);
    abort = 1'b0;
    n_cmp++;
    if ({busy, word_ready, done} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_in_load: {busy,word_ready,done} got %b required 000",
               {busy, word_ready, done});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_load();
    test_stall();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    test_signature();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Transmit end of the serial configuration chain.
- Accepts configuration words over a valid/ready stream, serializes them LSB-first and drives the head of a chain of config cells.
- Drives exactly CHAIN_LEN shift cycles per load, stalls cleanly when words are late, and signals completion.
- Sits between the bitstream source (DMA/host bridge) and the first switch/PE config cell of an array.

Parameters:
- CHAIN_LEN, 64, total config bits in the downstream chain (≥1).
- WORD_W, 32, width of incoming configuration words (≥2).
- SIG_W, 16, width of readback signature (optional feature only).

Ports:
- config_clk  in  1  clock.
- config_reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- abort  in  1  cancels the load in progress; return to IDLE.
- word_data  in  WORD_W  configuration word; bit0 is shifted first.
- word_valid  in  1  word_data valid.
- word_ready  out  1  loader accepts word this cycle.
- cfg_bit  out  1  serial data to the chain head config_in.
- cfg_en  out  1  shift enable / clock-gate enable for the chain; a bit is consumed on every cycle it is high.
- cfg_tail  in  1  chain tail config_out (loops back).
- busy  out  1  high in LOAD and SHIFT.
- done  out  1  one-cycle pulse when all CHAIN_LEN bits have been shifted.
- sig_out  out  SIG_W  readback signature.

Behaviour:
- Reset (async, config_reset low): state IDLE; word_ready, cfg_bit, cfg_en, busy, done all 0; sig_out 0; counters 0.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 -> LOAD.
  - remaining=CHAIN_LEN.
  - Signature cleared.
- LOAD:
  - word_ready=1.
  - On word_valid&word_ready: capture word into shift register; bit_idx=0; -> SHIFT.
  - Without word_valid: stay; cfg_en=0 (stall, no bit lost).
- SHIFT, each cycle:
  - cfg_bit=sreg[bit_idx] and cfg_en=1.
  - remaining decrements; bit_idx increments.
  - When remaining reaches 1 on this cycle (last bit): -> DONE.
  - Else when bit_idx==WORD_W-1: word_ready=1 this cycle.
    - If word_valid: reload and continue SHIFT next cycle with no bubble.
    - Else: -> LOAD.
- Latency: a word accepted in cycle N puts its bit0 on cfg_bit/cfg_en in cycle N+1.
- Partial final word: only the low (CHAIN_LEN mod WORD_W) bits are shifted; upper bits are discarded.
  - Exact multiples use all bits.
  - Exactly ceil(CHAIN_LEN/WORD_W) words are accepted per load.
- DONE:
  - done=1 for one cycle; cfg_en=0.
  - Next state IDLE.
  - start in DONE is ignored.
- cfg_en high count per completed load is exactly CHAIN_LEN. cfg_bit is 0 whenever cfg_en=0.
- abort (any non-IDLE state):
  - Next state IDLE.
  - cfg_en/word_ready drop next cycle; done is not pulsed.
  - abort has priority over a simultaneous handshake: the word is not captured and word_ready is forced 0 that cycle.
- start while busy: ignored.
- busy=1 in LOAD and SHIFT only.
- Counters:
  - remaining is $clog2(CHAIN_LEN+1) bits.
  - bit_idx is $clog2(WORD_W) bits and wraps to 0 on reload.

Optional Feature:
- Macro CONFIG_READBACK_SIG_EN.
- Defined:
  - On every cfg_en=1 cycle: sig = {sig[SIG_W-2:0], sig[SIG_W-1]^cfg_tail}, i.e. a rotating XOR of the previous chain contents pushed out of the tail.
  - sig_out holds its value from DONE until the next start clears it.
- Undefined: sig_out tied 0; no signature register.

Decomposition:
- Package config_loader_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, DONE);
  - default constants CFG_CHAIN_LEN_DEF and CFG_WORD_W_DEF;
  - function cfg_words(chain_len, word_w) = ceil division.
- One sub-module is natural: cfg_word_serializer (word shift register + bit_idx + last-bit flag), instantiated once.
- The FSM and remaining counter stay in the top module.

Test Plan:
- CHAIN_LEN=40, WORD_W=32; words 0xA5A5_0F0F and 0x0000_00C3 always valid:
  - exactly 40 cfg_en cycles, contiguous, with no bubble at the word boundary;
  - cfg_bit stream is the LSB-first bits of word0 then 0xC3 (8 bits);
  - done pulses once, 1 cycle after the last bit;
  - 2 handshakes total.
- Same load with word_valid withheld 5 cycles before word1:
  - cfg_en low for those 5 cycles, then resumes with bit0 of word1;
  - still 40 enables total.
- abort asserted in the cycle of the 20th shift:
  - cfg_en=0 next cycle; no done; busy=0; state IDLE;
  - a following start performs a full clean 40-bit load.
- start asserted during SHIFT and during DONE -> ignored; bit count and word count unchanged.
- config_reset pulled low mid-SHIFT -> all outputs 0 immediately (asynchronously); after release, IDLE with word_ready=0.
- CONFIG_READBACK_SIG_EN, SIG_W=16:
  - preload chain model with all-ones, then load 40 bits;
  - sig_out matches the reference model of the rotate-XOR over 40 ones;
  - with the macro undefined, sig_out==0.
